// File: rtl/combat_pkg.sv
// rtl/combat_pkg.sv - shared types, sprite sizes and box overlap helper for enemy combat
package combat_pkg;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    COOLDOWN     = 2'd1,
    WAIT_RELEASE = 2'd2
  } strike_state_t;

  localparam int ENEMY_W  = 26;
  localparam int ENEMY_H  = 26;
  localparam int PLAYER_W = 18;
  localparam int PLAYER_H = 20;

  // Half-open box [x0,x1) x [y0,y1); 10 bits so screen coordinates plus sprite size never wrap.
  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
  } box_t;

  // Strict compares: boxes that only share an edge do not overlap.
  function automatic logic box_overlap(input box_t a, input box_t b);
    return (a.x0 < b.x1) && (b.x0 < a.x1) && (a.y0 < b.y1) && (b.y0 < a.y1);
  endfunction

endpackage

// File: rtl/enemy_life.sv
// rtl/enemy_life.sv - per-enemy HP, alive, respawn and attack-period bookkeeping
module enemy_life
  import combat_pkg::*;
#(
  parameter int ENEMY_HP         = 3,
  parameter int ENEMY_ATK_PERIOD = 30,
  parameter int RESPAWN_FRAMES   = 60
) (
  input  logic game_frame_clk_rising_edge,
  input  logic Reset,
  input  logic run,           // low once the player is dead: everything holds
  input  logic hit,           // strike fired this frame and its box covers this enemy
  input  logic attack_ready,  // enemy adjacent to player and idle
  output logic is_alive,
  output logic attacked,      // registered one-frame hit pulse
  output logic kill,          // combinational: this frame's hit takes the last HP
  output logic fire_req       // combinational: enemy deals damage this frame
);

  localparam int HP_W  = $clog2(ENEMY_HP + 1);
  localparam int RSP_W = $clog2(RESPAWN_FRAMES + 1);
  localparam int ATK_W = $clog2(ENEMY_ATK_PERIOD + 1);

  logic [HP_W-1:0]  hp_q, hp_d;
  logic             alive_q, alive_d;
  logic [RSP_W-1:0] rsp_q, rsp_d;
  logic [ATK_W-1:0] atk_q, atk_d;
  logic             attacked_q, attacked_d;
  logic             hit_ok;

  // Next-state: hits and kills, respawn countdown, enemy attack period.
  always_comb begin
    hit_ok     = run & hit & alive_q;
    fire_req   = run & attack_ready & alive_q & (atk_q == '0);
    kill       = hit_ok & (hp_q == HP_W'(1));
    hp_d       = hp_q;
    alive_d    = alive_q;
    rsp_d      = rsp_q;
    atk_d      = atk_q;
    attacked_d = hit_ok;
    if (run) begin
      if (atk_q != '0) begin
        atk_d = atk_q - 1'b1;
      end
      if (fire_req) begin
        atk_d = ATK_W'(ENEMY_ATK_PERIOD - 1);
      end
      if (alive_q) begin
        if (hit_ok) begin
          hp_d = hp_q - 1'b1;
          if (kill) begin
            alive_d = 1'b0;
            rsp_d   = RSP_W'(RESPAWN_FRAMES - 1);
          end
        end
      end else if (rsp_q == '0) begin
        alive_d = 1'b1;
        hp_d    = HP_W'(ENEMY_HP);
        atk_d   = '0;
      end else begin
        rsp_d = rsp_q - 1'b1;
      end
    end
  end

  // State registers, synchronous active-high reset.
  always_ff @(posedge game_frame_clk_rising_edge) begin
    if (Reset) begin
      hp_q       <= HP_W'(ENEMY_HP);
      alive_q    <= 1'b1;
      rsp_q      <= '0;
      atk_q      <= '0;
      attacked_q <= 1'b0;
    end else begin
      hp_q       <= hp_d;
      alive_q    <= alive_d;
      rsp_q      <= rsp_d;
      atk_q      <= atk_d;
      attacked_q <= attacked_d;
    end
  end

  assign is_alive = alive_q;
  assign attacked = attacked_q;

endmodule

// File: rtl/enemy_combat_ctrl.sv
// rtl/enemy_combat_ctrl.sv - player strike FSM, hit detection, player HP and score
module enemy_combat_ctrl
  import combat_pkg::*;
#(
  parameter int NUM_ENEMY        = 4,
  parameter int ENEMY_HP         = 3,
  parameter int PLAYER_HP        = 8,
  parameter int ATTACK_COOLDOWN  = 8,
  parameter int ENEMY_ATK_PERIOD = 30,
  parameter int RESPAWN_FRAMES   = 60,
  parameter int REACH            = 12
) (
  input  logic                   game_frame_clk_rising_edge,
  input  logic                   Reset,
  input  logic                   Player_Attack,
  input  logic [8:0]             Player_X,
  input  logic [8:0]             Player_Y,
  input  logic [1:0]             Player_Direction,
  input  logic [NUM_ENEMY*9-1:0] Enemy_X_Pos,
  input  logic [NUM_ENEMY*9-1:0] Enemy_Y_Pos,
  input  logic [NUM_ENEMY-1:0]   Enemy_Attack_Ready,
  output logic [NUM_ENEMY-1:0]   Enemy_Is_Attacked,
  output logic [NUM_ENEMY-1:0]   is_alive,
  output logic                   Player_Is_Attacked,
  output logic [3:0]             Player_HP,
  output logic                   Player_Dead,
  output logic [7:0]             Score
);

  localparam logic [1:0] S_IDLE         = IDLE;
  localparam logic [1:0] S_COOLDOWN     = COOLDOWN;
  localparam logic [1:0] S_WAIT_RELEASE = WAIT_RELEASE;

  localparam int CNT_W = $clog2(ATTACK_COOLDOWN + 1);
  localparam int KW    = $clog2(NUM_ENEMY + 1);

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           hp_q, hp_d;
  logic                 dead_q, dead_d;
  logic                 pia_q, pia_d;
  logic [7:0]           score_q, score_d;

  logic                 strike_fire;
  box_t                 strike_box;
  logic [9:0]           px, py;
  logic [NUM_ENEMY-1:0] hit_vec;
  logic [NUM_ENEMY-1:0] kill_vec;
  logic [NUM_ENEMY-1:0] fire_vec;
  logic [KW-1:0]        kills;
  logic [8:0]           score_sum;

  // Strike FSM: one strike per press, then cooldown, then wait for key release.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    strike_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Player_Attack && !dead_q) begin
          strike_fire = 1'b1;
          state_d     = S_COOLDOWN;
          cnt_d       = CNT_W'(ATTACK_COOLDOWN - 1);
        end
      end
      S_COOLDOWN: begin
        if (cnt_q == '0) begin
          state_d = Player_Attack ? S_WAIT_RELEASE : S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT_RELEASE: begin
        if (!Player_Attack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strike box in front of the player; left/up clamp at the screen edge instead of wrapping.
  always_comb begin
    px         = {1'b0, Player_X};
    py         = {1'b0, Player_Y};
    strike_box = '0;
    case (dir_t'(Player_Direction))
      DIR_RIGHT: begin
        strike_box.x0 = px + 10'(PLAYER_W);
        strike_box.x1 = px + 10'(PLAYER_W + REACH);
        strike_box.y0 = py;
        strike_box.y1 = py + 10'(PLAYER_H);
      end
      DIR_LEFT: begin
        strike_box.x0 = (px >= 10'(REACH)) ? px - 10'(REACH) : 10'd0;
        strike_box.x1 = px;
        strike_box.y0 = py;
        strike_box.y1 = py + 10'(PLAYER_H);
      end
      DIR_UP: begin
        strike_box.x0 = px;
        strike_box.x1 = px + 10'(PLAYER_W);
        strike_box.y0 = (py >= 10'(REACH)) ? py - 10'(REACH) : 10'd0;
        strike_box.y1 = py;
      end
      default: begin
        strike_box.x0 = px;
        strike_box.x1 = px + 10'(PLAYER_W);
        strike_box.y0 = py + 10'(PLAYER_H);
        strike_box.y1 = py + 10'(PLAYER_H + REACH);
      end
    endcase
  end

  for (genvar i = 0; i < NUM_ENEMY; i++) begin : g_enemy
    box_t ebox;
    assign ebox.x0    = {1'b0, Enemy_X_Pos[9*i +: 9]};
    assign ebox.x1    = {1'b0, Enemy_X_Pos[9*i +: 9]} + 10'(ENEMY_W);
    assign ebox.y0    = {1'b0, Enemy_Y_Pos[9*i +: 9]};
    assign ebox.y1    = {1'b0, Enemy_Y_Pos[9*i +: 9]} + 10'(ENEMY_H);
    assign hit_vec[i] = strike_fire & box_overlap(strike_box, ebox);

    enemy_life #(
      .ENEMY_HP         (ENEMY_HP),
      .ENEMY_ATK_PERIOD (ENEMY_ATK_PERIOD),
      .RESPAWN_FRAMES   (RESPAWN_FRAMES)
    ) u_life (
      .game_frame_clk_rising_edge (game_frame_clk_rising_edge),
      .Reset                      (Reset),
      .run                        (~dead_q),
      .hit                        (hit_vec[i]),
      .attack_ready               (Enemy_Attack_Ready[i]),
      .is_alive                   (is_alive[i]),
      .attacked                   (Enemy_Is_Attacked[i]),
      .kill                       (kill_vec[i]),
      .fire_req                   (fire_vec[i])
    );
  end

  // Player damage (at most one point per frame) and saturating kill score.
  always_comb begin
    pia_d = |fire_vec;
    hp_d  = hp_q;
    if (pia_d && (hp_q != 4'd0)) begin
      hp_d = hp_q - 4'd1;
    end
    dead_d = (hp_d == 4'd0);
    kills  = '0;
    for (int i = 0; i < NUM_ENEMY; i++) begin
      kills = kills + KW'(kill_vec[i]);
    end
    score_sum = 9'(score_q) + 9'(kills);
    score_d   = (score_sum > 9'd255) ? 8'd255 : score_sum[7:0];
  end

  // Registered state and outputs, synchronous active-high reset.
  always_ff @(posedge game_frame_clk_rising_edge) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hp_q    <= 4'(PLAYER_HP);
      dead_q  <= 1'b0;
      pia_q   <= 1'b0;
      score_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      dead_q  <= dead_d;
      pia_q   <= pia_d;
      score_q <= score_d;
    end
  end

  assign Player_Is_Attacked = pia_q;
  assign Player_HP          = hp_q;
  assign Player_Dead        = dead_q;
  assign Score              = score_q;

endmodule

// File: tb/tb_enemy_combat_ctrl.sv
// tb/tb_enemy_combat_ctrl.sv - scoreboard bench for enemy_combat_ctrl
module tb_enemy_combat_ctrl;

  localparam int S_EIA   = 0;
  localparam int S_ALIVE = 1;
  localparam int S_PIA   = 2;
  localparam int S_HP    = 3;
  localparam int S_DEAD  = 4;
  localparam int S_SCORE = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        atk;
  logic [8:0]  px, py;
  logic [1:0]  dir;
  logic [35:0] ex_pos, ey_pos;
  logic [3:0]  ready;
  logic [3:0]  eia, alive;
  logic        pia, dead;
  logic [3:0]  hp;
  logic [7:0]  score;

  typedef struct {
    string tag;
    int    sel;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  enemy_combat_ctrl dut (
    .game_frame_clk_rising_edge (clk),
    .Reset                      (rst),
    .Player_Attack              (atk),
    .Player_X                   (px),
    .Player_Y                   (py),
    .Player_Direction           (dir),
    .Enemy_X_Pos                (ex_pos),
    .Enemy_Y_Pos                (ey_pos),
    .Enemy_Attack_Ready         (ready),
    .Enemy_Is_Attacked          (eia),
    .is_alive                   (alive),
    .Player_Is_Attacked         (pia),
    .Player_HP                  (hp),
    .Player_Dead                (dead),
    .Score                      (score)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int observe(input int sel);
    case (sel)
      S_EIA:   return int'(eia);
      S_ALIVE: return int'(alive);
      S_PIA:   return int'(pia);
      S_HP:    return int'(hp);
      S_DEAD:  return int'(dead);
      default: return int'(score);
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  // One frame: edge, settle, then compare everything queued for this frame.
  task automatic frame();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic set_enemy(input int i, input int x, input int y);
    ex_pos[9*i +: 9] = 9'(x);
    ey_pos[9*i +: 9] = 9'(y);
  endtask

  task automatic expect_reset_vals(input string tag);
    expect_out({tag, "_eia"},   S_EIA,   0);
    expect_out({tag, "_alive"}, S_ALIVE, 15);
    expect_out({tag, "_pia"},   S_PIA,   0);
    expect_out({tag, "_hp"},    S_HP,    8);
    expect_out({tag, "_dead"},  S_DEAD,  0);
    expect_out({tag, "_score"}, S_SCORE, 0);
  endtask

  // Single-frame press, then enough idle frames for the cooldown to expire.
  task automatic strike(input string tag, input int exp_eia);
    atk = 1'b1;
    expect_out(tag, S_EIA, exp_eia);
    frame();
    atk = 1'b0;
    repeat (10) frame();
  endtask

  initial begin
    int hp_exp;
    logic fired;
    rst = 1'b1; atk = 1'b0; px = 9'd30; py = 9'd62; dir = 2'd3; ready = 4'b0000;
    ex_pos = '0; ey_pos = '0;
    set_enemy(0, 50, 60); set_enemy(1, 300, 400); set_enemy(2, 350, 400); set_enemy(3, 400, 400);
    expect_reset_vals("reset");
    frame();
    rst = 1'b0;

    // single press hits enemy0 only
    atk = 1'b1;
    expect_out("t1_eia", S_EIA, 1);
    frame();
    atk = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expect_out("t1_quiet", S_EIA, 0);
      frame();
    end

    // holding the key strikes once; a fresh press strikes again and kills
    atk = 1'b1;
    expect_out("t2_first", S_EIA, 1);
    frame();
    for (int i = 1; i < 40; i++) begin
      expect_out("t2_hold", S_EIA, 0);
      frame();
    end
    atk = 1'b0;
    expect_out("t2_release", S_EIA, 0);
    frame();
    atk = 1'b1;
    expect_out("t2_kill_eia", S_EIA, 1);
    expect_out("t2_kill_alive", S_ALIVE, 14);
    expect_out("t2_kill_score", S_SCORE, 1);
    frame();
    atk = 1'b0;
    for (int i = 0; i < 59; i++) begin
      expect_out("t2_dead_wait", S_ALIVE, 14);
      frame();
    end
    expect_out("t2_respawn", S_ALIVE, 15);
    frame();

    // right strike box is [48,60): touching either edge misses
    set_enemy(0, 60, 60); strike("t3_x60", 0);
    set_enemy(0, 59, 60); strike("t3_x59", 1);
    set_enemy(0, 22, 60); strike("t3_x22", 0);
    set_enemy(0, 23, 60); strike("t3_x23", 1);

    // left strike clamps at 0; enemy0 (1 HP left) dies, enemy2 also hit
    px = 9'd5; py = 9'd100; dir = 2'd1;
    set_enemy(0, 0, 100); set_enemy(1, 300, 100); set_enemy(2, 0, 110);
    expect_out("t4_alive", S_ALIVE, 14);
    expect_out("t4_score", S_SCORE, 2);
    strike("t4_left", 5);
    strike("t4_dead_skip", 4);
    set_enemy(0, 300, 300); set_enemy(2, 350, 300);

    // down box x[100,118) y[120,132); up box x[100,118) y[0,10)
    px = 9'd100; py = 9'd100; dir = 2'd0;
    set_enemy(3, 110, 131); strike("t4_down_hit", 8);
    set_enemy(3, 110, 132); strike("t4_down_miss", 0);
    py = 9'd10; dir = 2'd2;
    set_enemy(3, 117, 0); strike("t4_up_hit", 8);
    set_enemy(3, 118, 0); strike("t4_up_miss", 0);
    set_enemy(3, 400, 400);
    repeat (70) frame();

    // two enemies ready: one damage per 30 frames until the player dies
    ready  = 4'b0011;
    hp_exp = 8;
    for (int k = 1; k <= 211; k++) begin
      fired = ((k - 1) % 30) == 0;
      if (fired) hp_exp--;
      expect_out("t5_pia", S_PIA, int'(fired));
      expect_out("t5_hp", S_HP, hp_exp);
      expect_out("t5_dead", S_DEAD, int'(hp_exp == 0));
      frame();
    end

    // dead player: no damage, no strikes, score frozen
    ready = 4'b1111;
    set_enemy(0, 110, 0);
    for (int k = 0; k < 20; k++) begin
      expect_out("t6_pia", S_PIA, 0);
      expect_out("t6_hp", S_HP, 0);
      expect_out("t6_dead", S_DEAD, 1);
      frame();
    end
    ready = 4'b0000;
    expect_out("t6_score", S_SCORE, 2);
    strike("t6_no_strike", 0);

    rst = 1'b1;
    expect_reset_vals("t6_rst1");
    frame();
    rst = 1'b0;
    atk = 1'b1;
    expect_out("t6_post_rst_hit", S_EIA, 1);
    frame();
    atk = 1'b0;
    repeat (3) frame();
    rst = 1'b1;
    expect_reset_vals("t6_rst_cool");
    frame();
    rst = 1'b0;
    atk = 1'b1;
    expect_out("t6_fsm_idle", S_EIA, 1);
    frame();
    atk = 1'b0;
    frame();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
